// File: rtl/rotabit_pkg.sv
// Shared definitions for the rotating-bit receive path: default sizing, FSM states
// and the rotation helper.
package rotabit_pkg;

    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_MISS_LIMIT = 3;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        SCAN,
        REPORT
    } state_t;

    function automatic logic [DEF_WIDTH-1:0] rotr(input logic [DEF_WIDTH-1:0] word,
                                                   input int unsigned          n);
        int unsigned s;
        s = n % DEF_WIDTH;
        return (word >> s) | (word << (DEF_WIDTH - s));
    endfunction

endpackage

// File: rtl/rotabit_lock_tracker.sv
// Lock tracker: watches successive decode reports and declares lock when the source
// advances by exactly one rotation step per word.
module rotabit_lock_tracker
    import rotabit_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned MISS_LIMIT = DEF_MISS_LIMIT,
    parameter int unsigned OW         = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          report,
    input  logic [OW-1:0] offset,
    input  logic          match,
    output logic          locked
);

    localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

    logic [OW-1:0] prev_off;
    logic          prev_valid;
    logic [1:0]    hits;
    logic [MW-1:0] misses;
    logic [OW-1:0] next_off;
    logic          hit;

    // Expected successor offset wraps from WIDTH-1 back to 0.
    assign next_off = (prev_off == OW'(WIDTH - 1)) ? '0 : prev_off + OW'(1);
    assign hit      = match && prev_valid && (offset == next_off);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev_off   <= '0;
            prev_valid <= 1'b0;
            hits       <= '0;
            misses     <= '0;
            locked     <= 1'b0;
        end else if (report) begin
            prev_off   <= offset;
            prev_valid <= match;
            if (!locked) begin
                if (!hit) begin
                    hits <= '0;
                end else if (hits == 2'd1) begin
                    hits   <= 2'd2;
                    locked <= 1'b1;
                    misses <= '0;
                end else begin
                    hits <= hits + 2'd1;
                end
            end else begin
                if (hit) begin
                    misses <= '0;
                end else if (misses == MW'(MISS_LIMIT - 1)) begin
                    locked <= 1'b0;
                    hits   <= '0;
                    misses <= '0;
                end else begin
                    misses <= misses + MW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rotabit_derotator.sv
// Receive-side derotator: finds the left-rotation between an accepted word and the
// stored reference by rotating the word right one step per cycle.
module rotabit_derotator
    import rotabit_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned MISS_LIMIT = DEF_MISS_LIMIT,
    parameter int unsigned OW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_load,
    input  logic [WIDTH-1:0] ref_word,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    output logic [OW-1:0]    out_offset,
    output logic             out_match,
    output logic             locked
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] sh;
    logic [OW-1:0]    k;
    logic             cmp_hit;
    logic             last_k;
    logic             accept;
    logic             finish;

    assign cmp_hit = (sh == ref_q);
    assign last_k  = (k == OW'(WIDTH - 1));
    assign accept  = (state == READY) && in_valid && !ref_load;
    assign finish  = (state == SCAN) && (state_nx == REPORT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ref_load) state_nx = READY;
            READY:   if (ref_load) state_nx = READY;
                     else if (in_valid) state_nx = SCAN;
            SCAN:    if (ref_load) state_nx = READY;
                     else if (cmp_hit || last_k) state_nx = REPORT;
            REPORT:  state_nx = READY;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ref_q      <= '0;
            sh         <= '0;
            k          <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_offset <= '0;
            out_match  <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == READY);
            out_valid <= finish;
            if (ref_load) begin
                ref_q <= ref_word;
            end
            if (accept) begin
                sh <= in_word;
                k  <= '0;
            end else if (state == SCAN && !cmp_hit) begin
                sh <= {sh[0], sh[WIDTH-1:1]};
                k  <= k + OW'(1);
            end
            if (finish) begin
                out_match  <= cmp_hit;
                out_offset <= cmp_hit ? k : '0;
            end
        end
    end

    rotabit_lock_tracker #(
        .WIDTH      (WIDTH),
        .MISS_LIMIT (MISS_LIMIT),
        .OW         (OW)
    ) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .clear  (ref_load),
        .report (out_valid),
        .offset (out_offset),
        .match  (out_match),
        .locked (locked)
    );

endmodule

// File: tb/tb_rotabit_derotator.sv
// Bench for rotabit_derotator: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed timing and offsets.
module tb_rotabit_derotator;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ref_load = 1'b0;
    logic [15:0] ref_word = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_word = '0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_offset;
    logic        out_match;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rotabit_derotator #(
        .WIDTH      (16),
        .MISS_LIMIT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ref_load   (ref_load),
        .ref_word   (ref_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_offset (out_offset),
        .out_match  (out_match),
        .locked     (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] w, input int n);
        logic [15:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
        return r;
    endfunction

    // Smallest k with rotl(ref,k) == w, or -1.
    function automatic int find_k(input logic [15:0] rf, input logic [15:0] w);
        for (int i = 0; i < W; i++)
            if (rotl(rf, i) == w) return i;
        return -1;
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] m_ref = '0;
    bit m_ready = 0, m_pending = 0, m_match = 0;
    int m_due = 0, m_off = 0;
    bit m_locked = 0, m_prev_valid = 0;
    int m_prev_off = 0, m_hits = 0, m_misses = 0;

    function automatic void lock_clear();
        m_locked = 0; m_prev_valid = 0; m_prev_off = 0; m_hits = 0; m_misses = 0;
    endfunction

    function automatic void lock_update(input int off, input bit m);
        bit hit;
        hit = m && m_prev_valid && (off == (m_prev_off + 1) % W);
        m_prev_off = off;
        m_prev_valid = m;
        if (!m_locked) begin
            m_hits = hit ? m_hits + 1 : 0;
            if (m_hits == 2) begin m_locked = 1; m_misses = 0; end
        end else begin
            m_misses = hit ? 0 : m_misses + 1;
            if (m_misses == 3) begin m_locked = 0; m_hits = 0; m_misses = 0; end
        end
    endfunction

    always @(negedge clk) begin
        bit exp_v;
        int k;
        exp_v = m_pending && (m_due == cyc);
        check("in_ready", in_ready, 32'(m_ready));
        check("out_valid", out_valid, 32'(exp_v));
        check("locked", locked, 32'(m_locked));
        if (exp_v) begin
            check("out_offset", out_offset, 32'(m_off));
            check("out_match", out_match, 32'(m_match));
        end
        if (rst) begin
            m_ref = '0; m_ready = 0; m_pending = 0;
            lock_clear();
        end else if (ref_load) begin
            m_ref = ref_word; m_ready = 1; m_pending = 0;
            lock_clear();
        end else if (exp_v) begin
            m_pending = 0; m_ready = 1;
            lock_update(m_off, m_match);
        end else if (m_ready && in_valid) begin
            k = find_k(m_ref, in_word);
            m_pending = 1; m_ready = 0;
            if (k >= 0) begin m_due = cyc + k + 2; m_off = k; m_match = 1; end
            else begin m_due = cyc + W + 1; m_off = 0; m_match = 0; end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ref(input logic [15:0] w);
        ref_load = 1'b1;
        ref_word = w;
        tick();
        ref_load = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        if (in_ready !== 1'b1) check("ready_timeout", in_ready, 1);
    endtask

    task automatic send(input logic [15:0] w, output int lat, output int off, output int m);
        int n, e0;
        wait_ready();
        in_valid = 1'b1;
        in_word = w;
        e0 = cyc;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
        lat = cyc - e0;
        off = 32'(out_offset);
        m = 32'(out_match);
    endtask

    // Start a non-matching scan and hold it until cycle E0+3.
    task automatic start_scan_to_e3();
        wait_ready();
        in_valid = 1'b1;
        in_word = 16'h0000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic count_valid(input string name, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        check(name, seen, 0);
    endtask

    initial begin
        int lat, off, m, step, r;
        logic [15:0] cur;
        logic [15:0] refs [6];
        refs = '{16'h0001, 16'h5555, 16'h0000, 16'hFFFF, 16'h00FF, 16'h8421};

        // Reset and IDLE: in_valid must be ignored.
        rst = 1'b1; in_valid = 1'b1; in_word = 16'h0001;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_out_valid", out_valid, 0);
        check("rst_offset", out_offset, 0);
        check("rst_match", out_match, 0);
        check("rst_locked", locked, 0);
        in_valid = 1'b0;
        load_ref(16'h0001);
        check("ref_ready", in_ready, 1);

        send(16'h0008, lat, off, m);
        check("t2_lat", lat, 5); check("t2_off", off, 3); check("t2_match", m, 1);

        send(16'h0000, lat, off, m);
        check("t3_lat", lat, 17); check("t3_off", off, 0); check("t3_match", m, 0);
        check("t3_ready_at_report", in_ready, 0);
        tick();
        check("t3_ready_after", in_ready, 1);

        // Step sequence locks after third report.
        send(16'h0001, lat, off, m); check("t4_off0", off, 0);
        send(16'h0002, lat, off, m); check("t4_off1", off, 1);
        send(16'h0004, lat, off, m); check("t4_off2", off, 2);
        check("t4_lock_same_cycle", locked, 0);
        tick();
        check("t4_locked", locked, 1);
        send(16'h0100, lat, off, m);
        send(16'h0100, lat, off, m);
        tick(); check("t4_still_locked", locked, 1);
        send(16'h0100, lat, off, m); check("t4_off8", off, 8);
        tick(); check("t4_unlocked", locked, 0);
        send(16'h4000, lat, off, m); check("t4_off14", off, 14);
        send(16'h8000, lat, off, m); check("t4_off15", off, 15);
        send(16'h0001, lat, off, m); check("t4_wrap_off0", off, 0);
        tick(); check("t4_wrap_locked", locked, 1);

        // Reset mid-scan while locked.
        start_scan_to_e3();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_locked", locked, 0);
        count_valid("t6_rst_no_valid", 20);

        // ref_load mid-scan: abort, then the new reference is used.
        load_ref(16'h0001);
        start_scan_to_e3();
        load_ref(16'h0010);
        check("t6_ld_ready", in_ready, 1);
        count_valid("t6_ld_no_valid", 20);
        send(16'h0100, lat, off, m);
        check("t6_new_ref_off", off, 4); check("t6_new_ref_lat", lat, 6);

        // Periodic / degenerate references.
        load_ref(16'h5555);
        send(16'hAAAA, lat, off, m);
        check("t5_5555_off", off, 1); check("t5_5555_lat", lat, 3);
        load_ref(16'h0000);
        send(16'h0000, lat, off, m);
        check("t5_zero_off", off, 0); check("t5_zero_lat", lat, 2); check("t5_zero_match", m, 1);
        load_ref(16'hFFFF);
        send(16'hFFFF, lat, off, m);
        check("t5_ones_off", off, 0);

        // Randomized traffic checked by the model.
        cur = 16'h0001;
        load_ref(cur);
        step = 0;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom % 100);
            rst = ($urandom % 300 == 0);
            ref_load = (r < 2);
            if (ref_load) begin
                cur = ($urandom % 3 == 0) ? 16'($urandom) : refs[$urandom % 6];
                ref_word = cur;
            end
            in_valid = ($urandom % 4 != 0);
            if ($urandom % 8 == 0) in_word = 16'($urandom);
            else in_word = rotl(cur, step % W);
            if (in_ready && in_valid && !ref_load && !rst)
                step += ($urandom % 6 == 0) ? int'($urandom % 16) : 1;
            tick();
        end
        rst = 1'b0; ref_load = 1'b0; in_valid = 1'b0;
        repeat (25) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
